// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mult_div_unit_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_cond_negate.sv
// Passes the input through, or its two's complement when neg is set.
module cond_negate
  import mult_div_unit_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply and restoring divide with HI/LO result
// registers; all state advances on the falling clock edge.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               is_div_q, neg_p, neg_r, dbz_pend;
  logic [WIDTH-1:0]   mag_a, mag_b, rem;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               b_zero;

  assign b_zero = (b == '0);
  assign busy   = (state != IDLE);

  cond_negate #(.W(WIDTH)) u_neg_a (.din(a), .neg(op_is_signed(op) & a[WIDTH-1]), .dout(a_mag));
  cond_negate #(.W(WIDTH)) u_neg_b (.din(b), .neg(op_is_signed(op) & b[WIDTH-1]), .dout(b_mag));

  cond_negate #(.W(2*WIDTH)) u_fix_prod (.din(acc),            .neg(neg_p), .dout(prod_fix));
  cond_negate #(.W(WIDTH))   u_fix_quo  (.din(acc[WIDTH-1:0]), .neg(neg_p), .dout(quo_fix));
  cond_negate #(.W(WIDTH))   u_fix_rem  (.din(rem),            .neg(neg_r), .dout(rem_fix));

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : '0)};
  // Divide: acc[WIDTH-1:0] shifts the dividend out and the quotient in.
  assign div_shift = {rem, acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !cancel) state_nxt = (op_is_div(op) && b_zero) ? FIX : RUN;
      RUN: begin
        if (cancel)                          state_nxt = IDLE;
        else if (cnt == CNT_W'(WIDTH - 1))   state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      is_div_q    <= 1'b0;
      neg_p       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_pend    <= 1'b0;
      mag_a       <= '0;
      mag_b       <= '0;
      rem         <= '0;
      acc         <= '0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !cancel) begin
          cnt         <= '0;
          is_div_q    <= op_is_div(op);
          neg_p       <= op_is_signed(op) & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r       <= op_is_signed(op) & a[WIDTH-1];
          dbz_pend    <= op_is_div(op) & b_zero;
          mag_a       <= a_mag;
          mag_b       <= b_mag;
          rem         <= '0;
          div_by_zero <= 1'b0;
          // Divide-by-zero keeps the raw dividend so hi can return it unmodified.
          if (op_is_div(op)) acc <= {{WIDTH{1'b0}}, (b_zero ? a : a_mag)};
          else               acc <= {{WIDTH{1'b0}}, b_mag};
        end
        RUN: if (!cancel) begin
          cnt <= cnt + CNT_W'(1);
          if (is_div_q) begin
            rem            <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        FIX: if (!cancel) begin
          done        <= 1'b1;
          div_by_zero <= dbz_pend;
          // Most-negative / -1 needs no special case: the magnitude quotient
          // negates back onto itself and the remainder is zero.
          if (dbz_pend) begin
            hi <= acc[WIDTH-1:0];
            lo <= '1;
          end else if (is_div_q) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized scoreboard bench for mult_div_unit against a plain-arithmetic model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W = 16;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint ux, uy, sx, sy, p, q, r;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dbz = 1'b0;
    if (o == OP_MULTU || o == OP_MULT) begin
      p    = (o == OP_MULT) ? sx * sy : ux * uy;
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
    end else if (y == '0) begin
      e.hi  = x;
      e.lo  = '1;
      e.dbz = 1'b1;
    end else begin
      q    = (o == OP_DIV) ? sx / sy : ux / uy;
      r    = (o == OP_DIV) ? sx % sy : ux % uy;
      e.hi = r[W-1:0];
      e.lo = q[W-1:0];
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding result.
  always @(posedge clock) begin
    exp_t e;
    if (!reset && done) begin
      if (sb_q.size() == 0) chk("spurious_done", done, 0);
      else begin
        e = sb_q.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_by_zero", div_by_zero, e.dbz);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  // Drives start right after a rising edge so it is sampled on the next falling
  // edge; optionally pulses start again mid-run at iteration poke.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int poke);
    int n;
    exp_t e;
    e = model(o, x, y);
    start = 1'b1; op = o; a = x; b = y;
    sb_q.push_back(e);
    last_exp = e;
    @(negedge clock); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    chk("busy_after_start", busy, 1);
    n = 0;
    do begin
      if (poke > 0 && n == poke) begin
        start = 1'b1; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
      end else start = 1'b0;
      @(negedge clock);
      n++;
      @(posedge clock);
    end while (!done && n < 60);
    start = 1'b0;
    chk("latency", n, (o[1] && y == '0) ? 1 : W + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_dbz", div_by_zero, 0);
    @(posedge clock);
    reset = 1'b0;
    @(posedge clock);

    do_op(OP_MULTU, 16'hFFFF, 16'hFFFF, 0);
    do_op(OP_MULT,  16'hFFFD, 16'h0007, 0);
    do_op(OP_DIV,   16'hFFF9, 16'h0002, 0);
    do_op(OP_DIVU,  16'h0064, 16'h0000, 0);
    do_op(OP_MULTU, 16'h0003, 16'h0004, 0);
    do_op(OP_DIV,   16'h8000, 16'hFFFF, 0);
    do_op(OP_DIVU,  16'hFFFF, 16'h0010, 3);
    do_op(OP_DIV,   16'hFFF9, 16'h0000, 0);

    // start together with cancel in IDLE is ignored
    start = 1'b1; cancel = 1'b1; op = OP_MULTU; a = 16'h0005; b = 16'h0005;
    @(negedge clock); #1;
    start = 1'b0; cancel = 1'b0;
    chk("start_cancel_idle_busy", busy, 0);
    @(posedge clock);

    // cancel at iteration 5 leaves hi/lo/div_by_zero untouched
    do_op(OP_MULTU, 16'h00AB, 16'h0123, 0);
    start = 1'b1; op = OP_MULTU; a = 16'h1234; b = 16'h5678;
    @(negedge clock); #1;
    start = 1'b0;
    repeat (5) @(negedge clock);
    @(posedge clock);
    cancel = 1'b1;
    @(negedge clock); #1;
    cancel = 1'b0;
    chk("cancel_busy", busy, 0);
    repeat (20) @(posedge clock);
    chk("cancel_hi", hi, last_exp.hi);
    chk("cancel_lo", lo, last_exp.lo);
    chk("cancel_dbz", div_by_zero, last_exp.dbz);

    // asynchronous reset between edges mid-run
    @(posedge clock);
    start = 1'b1; op = OP_MULT; a = 16'h7FFF; b = 16'h8001;
    @(negedge clock); #1;
    start = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_hi", hi, 0);
    chk("midreset_lo", lo, 0);
    #3 reset = 1'b0;
    @(posedge clock);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]   o;
      logic [W-1:0] x, y;
      int           sel;
      o   = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      x   = (sel == 1) ? MOST_NEG : W'($urandom);
      y   = (sel == 0) ? '0 : (sel == 1 || sel == 2) ? '1 : W'($urandom);
      do_op(o, x, y, (i % 5 == 0) ? 2 : 0);
    end

    repeat (3) @(posedge clock);
    chk("queue_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit with HI/LO result registers, parametrised in operand width, for the pipelined CPU's EX stage. It extends the fixed 16-bit combinational ALU with signed and unsigned multiply and divide. A start/busy/done handshake lets the pipeline stall while the unit runs. Results are held in HI/LO until the next accepted operation completes.

Parameters:
WIDTH, 16, operand width in bits and width of each of HI and LO; any value of 4 or more.
CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived; do not override).

Ports:
clock  input  1  system clock; all state updates occur on the falling edge, matching the pipeline registers.
reset  input  1  asynchronous, active-high; clears all state immediately.
start  input  1  request a new operation; sampled on the falling edge.
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
a  input  WIDTH  multiplicand or dividend; sampled only when start is accepted.
b  input  WIDTH  multiplier or divisor; sampled only when start is accepted.
cancel  input  1  pipeline flush; aborts the current operation.
busy  output  1  high while state is not IDLE.
done  output  1  registered one-cycle pulse marking a completed result.
hi  output  WIDTH  multiply: upper product half; divide: remainder.
lo  output  WIDTH  multiply: lower product half; divide: quotient.
div_by_zero  output  1  set with done when a divide has b==0; cleared on the next accepted start.

Behaviour:
- Reset values: state=IDLE; busy=0; done=0; hi=0; lo=0; div_by_zero=0; counter=0; internal operand and accumulator registers=0.
- States are IDLE, RUN and FIX.
- IDLE to RUN: on the edge E0 where start=1 and cancel=0, latch op.
  - Signed ops: latch the magnitudes |a| and |b|, plus the result sign flags.
  - Set counter=0 and clear div_by_zero.
- Divide with b==0: go from IDLE straight to FIX instead of RUN.
- RUN: one iteration per edge, WIDTH iterations on edges E1..E_WIDTH, then go to FIX.
  - Multiply: shift-add over a 2*WIDTH-bit accumulator.
  - Divide: restoring division; remainder is WIDTH+1 bits wide internally.
- FIX, on edge E_WIDTH+1:
  - Apply two's-complement negation where required.
  - Write hi and lo, drive done=1 for exactly one cycle, return to IDLE.
- Latency: done is visible for the cycle following edge E_WIDTH+1, i.e. 17 edges after the start edge when WIDTH=16. Divide-by-zero: done follows edge E1.
- Signed multiply: the 2*WIDTH-bit product is negated when the signs of a and b differ.
- Signed divide:
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
  - Most-negative / -1 wraps: lo = most-negative value, hi = 0.
- Divide by zero: hi = a (unmodified), lo = all ones, div_by_zero = 1. No exception is raised.
- start while busy is ignored; no queueing.
- start on the same edge that IDLE is re-entered is not seen. Back-to-back: start may be accepted on the edge after the done edge.
- cancel while busy: go to IDLE on that edge; no done pulse; hi, lo and div_by_zero keep their previous values.
- cancel while IDLE has no effect. If start and cancel are both high in IDLE, cancel wins and start is ignored.
- reset asserted mid-operation: immediate return to reset values; no done pulse.
- hi and lo change only on a FIX edge or on reset.

Decomposition:
- Shared package holds:
  - op encodings OP_MULTU=2'b00, OP_MULT=2'b01, OP_DIVU=2'b10, OP_DIV=2'b11;
  - state encoding IDLE, RUN, FIX.
- Sub-module cond_negate: parametrised width; outputs the input, or its two's complement when a select bit is high.
  - Used for operand magnitudes and for result fixup.

Test Plan:
- WIDTH=16, MULTU a=FFFF b=FFFF -> after 17 edges: done pulse, hi=FFFE, lo=0001, busy low in the same cycle.
- MULT a=FFFD (-3) b=0007 -> hi=FFFF, lo=FFEB (-21). Then DIV a=FFF9 (-7) b=0002 -> lo=FFFD, hi=FFFF.
- DIVU a=0064 b=0000 -> done after 1 edge, hi=0064, lo=FFFF, div_by_zero=1. Next MULTU 3*4 -> div_by_zero=0, hi=0000, lo=000C.
- DIV a=8000 b=FFFF -> lo=8000, hi=0000. DIVU a=FFFF b=0010 -> lo=0FFF, hi=000F.
- Load hi/lo with a result, start MULTU, assert cancel at iteration 5 -> busy low next edge, no done, hi/lo unchanged. start pulsed during RUN -> ignored.
- Assert reset asynchronously mid-RUN (between edges) -> busy, done, hi and lo go to 0 immediately. Also rerun the first two cases with WIDTH=8 and WIDTH=32.
